// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, for the sync generator and for
// pixel generators that need to know the frame geometry.
package vga_pkg;
  // Counter width; totals up to 1024 fit.
  localparam int CNT_W = 10;

  localparam int VGA_H_VIS  = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_V_VIS  = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;

  localparam int VGA_H_TOT = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOT = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
endpackage

// File: rtl/vga_axis_cnt.sv
// One timing axis (horizontal or vertical): a wrapping position counter
// plus sync and visible flags registered together with the count, so the
// flags always describe the count currently on o_count.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int SYNC_START = 656,  // first position with sync low
  parameter int SYNC_END   = 752,  // first position after the sync pulse
  parameter int VIS        = 640
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_wrap,    // count sits on its last position
  output logic             o_sync_n,
  output logic             o_vis
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SS   = CNT_W'(SYNC_START);
  localparam logic [CNT_W-1:0] SE   = CNT_W'(SYNC_END);
  localparam logic [CNT_W-1:0] VL   = CNT_W'(VIS);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_next;
  logic             r_sync_n;
  logic             r_vis;

  // Next position: wrap from the last position back to 0.
  always_comb begin
    w_next = (r_count == LAST) ? '0 : r_count + CNT_W'(1);
  end

  // Advance count and decode flags from the position being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_sync_n <= 1'b1;
      r_vis    <= 1'b1;
    end else if (i_en) begin
      r_count  <= w_next;
      r_sync_n <= !((w_next >= SS) && (w_next < SE));
      r_vis    <= (w_next < VL);
    end
  end

  assign o_count  = r_count;
  assign o_wrap   = (r_count == LAST);
  assign o_sync_n = r_sync_n;
  assign o_vis    = r_vis;
endmodule

// File: rtl/vga_sync.sv
// VGA sync generator: x/y raster position, active-low hsync/vsync,
// video_on and a one-clk frame_start pulse, all advancing on pix_en.
// Define VGA_SYNC_FRAME_CNT_EN to add a 16-bit wrapping frame counter.
module vga_sync
  import vga_pkg::*;
#(
  parameter int H_VIS  = VGA_H_VIS,
  parameter int H_FP   = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP   = VGA_H_BP,
  parameter int V_VIS  = VGA_V_VIS,
  parameter int V_FP   = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP   = VGA_V_BP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  logic w_h_wrap, w_v_wrap, w_h_vis, w_v_vis, w_v_en, w_frame_end;
  logic r_frame_start;

  // Vertical axis steps only when the line wraps.
  assign w_v_en      = pix_en & w_h_wrap;
  assign w_frame_end = w_v_en & w_v_wrap;

  vga_axis_cnt #(
    .TOTAL(H_TOT), .SYNC_START(H_VIS + H_FP),
    .SYNC_END(H_VIS + H_FP + H_SYNC), .VIS(H_VIS)
  ) u_h (
    .clk(clk), .rst(rst), .i_en(pix_en), .o_count(x),
    .o_wrap(w_h_wrap), .o_sync_n(hsync), .o_vis(w_h_vis)
  );

  vga_axis_cnt #(
    .TOTAL(V_TOT), .SYNC_START(V_VIS + V_FP),
    .SYNC_END(V_VIS + V_FP + V_SYNC), .VIS(V_VIS)
  ) u_v (
    .clk(clk), .rst(rst), .i_en(w_v_en), .o_count(y),
    .o_wrap(w_v_wrap), .o_sync_n(vsync), .o_vis(w_v_vis)
  );

  // Both flags are registered alongside x/y, so the AND has zero latency.
  assign video_on = w_h_vis & w_v_vis;

  // Pulse on the edge entering (0,0) from the last position of the frame.
  always_ff @(posedge clk) begin
    if (rst) r_frame_start <= 1'b0;
    else     r_frame_start <= w_frame_end;
  end

  assign frame_start = r_frame_start;

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Count completed frames on the same edge frame_start asserts.
  always_ff @(posedge clk) begin
    if (rst)              r_frame_cnt <= '0;
    else if (w_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign frame_cnt = r_frame_cnt;
`endif
endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 SHALL have parameter H_VIS, default 640: visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96: hsync pulse width, in pixels.
REQ-004 SHALL have parameter H_BP, default 48: horizontal back porch, in pixels.
REQ-005 SHALL have parameter V_VIS, default 480: visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10: vertical front porch, in lines.
REQ-007 SHALL have parameter V_SYNC, default 2: vsync pulse width, in lines.
REQ-008 SHALL have parameter V_BP, default 33: vertical back porch, in lines.
REQ-009 SHALL have port clk, input, 1 bit: the single system clock; one clock; reset is synchronous and active-high.
REQ-010 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-011 SHALL have port pix_en, input, 1 bit: pixel-rate enable from the upstream clk_vga divider, one clk wide per pixel.
REQ-012 SHALL have port hsync, output, 1 bit: horizontal sync, active low.
REQ-013 SHALL have port vsync, output, 1 bit: vertical sync, active low.
REQ-014 SHALL have port video_on, output, 1 bit: high while the current pixel is visible.
REQ-015 SHALL have port x, output, 10 bits: current horizontal count.
REQ-016 SHALL have port y, output, 10 bits: current vertical count.
REQ-017 SHALL have port frame_start, output, 1 bit: one-clk pulse when position (0,0) is entered.

Function
REQ-018 SHALL define H_TOT = H_VIS+H_FP+H_SYNC+H_BP (800 by default) and V_TOT = V_VIS+V_FP+V_SYNC+V_BP (525 by default).
REQ-019 SHALL advance the counters only on clk edges where pix_en=1; with pix_en=0, all outputs hold, and frame_start is 0.
REQ-020 SHALL, on each advance, increment x, wrapping from H_TOT-1 to 0.
REQ-021 SHALL increment y only on an x wrap, wrapping from V_TOT-1 to 0; the x and y wraps occur on the same edge at (H_TOT-1, V_TOT-1).
REQ-022 SHALL register hsync, vsync and video_on in the same edge as x and y, so that they always describe the x/y currently output (zero relative latency).
REQ-023 SHALL drive hsync=0 when x is in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1], i.e. [656,751] by default, and 1 otherwise.
REQ-024 SHALL drive vsync=0 when y is in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1], i.e. [490,491] by default, and 1 otherwise.
REQ-025 SHALL drive video_on=1 iff x<H_VIS and y<V_VIS.
REQ-026 SHALL assert frame_start for exactly one clk, on the edge where x and y become (0,0) from (H_TOT-1, V_TOT-1).
REQ-027 SHALL use widths sufficient for the defaults; parameter totals above 1024 are unsupported.

Reset
REQ-028 SHALL, while rst=1 at a clk edge, set x=0, y=0, hsync=1, vsync=1, video_on=1, and frame_start=0, regardless of pix_en.
REQ-029 SHALL give rst priority over pix_en, and SHALL restart the frame from (0,0) when reset is applied mid-frame.
REQ-030 SHALL not pulse frame_start on reset; the first frame_start follows the first complete frame.

Configuration
REQ-031 SHALL, with macro VGA_SYNC_FRAME_CNT_EN defined, add output frame_cnt (16 bits, reset 0), incremented on the edge that frame_start asserts and wrapping 0xFFFF to 0.
REQ-032 SHALL, without VGA_SYNC_FRAME_CNT_EN, have no frame_cnt port and no counter logic, leaving all other behaviour identical.

Structure
REQ-033 SHALL place the default timing constants and the derived H_TOT/V_TOT in shared package vga_pkg, for reuse by pixel generators.
REQ-034 SHALL implement the x and y counters in a single sub-module, vga_axis_cnt (parameters: total, sync start, sync end, visible; outputs: count, wrap, sync_n, vis), instantiated once for the horizontal axis and once for the vertical axis.

Verification
REQ-035 SHALL cover: after reset, pix_en held 1 continuously -> x wraps every 800 clk, hsync low for exactly 96 clk starting at x=656.
REQ-036 SHALL cover: pix_en asserted once every 4 clk -> line period is 3200 clk, and outputs are stable on the non-enabled clks.
REQ-037 SHALL cover: a full frame with pix_en=1 -> frame_start pulses every 420000 clk, vsync low for 1600 clk at y=490..491, and video_on high for 307200 clk per frame.
REQ-038 SHALL cover: rst asserted at (x=700, y=300) -> next edge gives x=0, y=0, hsync=1, vsync=1, frame_start=0.
REQ-039 SHALL cover: rst and pix_en both 1 -> reset values win.
REQ-040 SHALL cover: with VGA_SYNC_FRAME_CNT_EN defined, 3 full frames -> frame_cnt=3; with frame_cnt preloaded to 0xFFFF, one more frame -> frame_cnt=0.
